// File: rtl/raizing_textram_ctrl.sv
// Extra-text memory controller: text VRAM, line-select and line-scroll RAMs with a
// 68000-style CPU port, three fixed-latency renderer read ports and a post-reset zero sweep.
module raizing_textram_ctrl #(
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int VRAM_AW        = 12
) (
    input  logic        CLK96,
    input  logic        RESET96,
    input  logic        CPU_CS_VRAM,
    input  logic        CPU_CS_SEL,
    input  logic        CPU_CS_SCR,
    input  logic        CPU_RNW,
    input  logic [11:0] CPU_ADDR,
    input  logic [15:0] CPU_DIN,
    input  logic        CPU_UDS,
    input  logic        CPU_LDS,
    output logic [15:0] CPU_DOUT,
    output logic        CPU_DTACK,
    output logic        CLEAR_BUSY,
    input  logic [11:0] TEXTVRAM_ADDR,
    output logic [15:0] TEXTVRAM_DATA,
    input  logic [7:0]  TEXTSELECT_ADDR,
    output logic [15:0] TEXTSELECT_DATA,
    input  logic [7:0]  TEXTSCROLL_ADDR,
    output logic [15:0] TEXTSCROLL_DATA
);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RD, S_ACK} state_t;

    logic [15:0] vram [0:(1<<VRAM_AW)-1];
    logic [15:0] sel  [0:255];
    logic [15:0] scr  [0:255];

    state_t             state;
    logic [VRAM_AW-1:0] cnt;
    logic [15:0]        cpu_rd_q;
    logic               any_cs;

    logic               vram_we, sel_we, scr_we;
    logic [VRAM_AW-1:0] wa_v;
    logic [7:0]         wa_8;
    logic [15:0]        wd;
    logic [1:0]         wbe;
    logic [15:0]        cpu_rd_mux;

    assign any_cs = CPU_CS_VRAM | CPU_CS_SEL | CPU_CS_SCR;

    // Single write port per RAM, shared by the sweep and the CPU; gated off during reset.
    always_comb begin
        vram_we = 1'b0;
        sel_we  = 1'b0;
        scr_we  = 1'b0;
        wa_v    = CPU_ADDR[VRAM_AW-1:0];
        wa_8    = CPU_ADDR[7:0];
        wd      = CPU_DIN;
        wbe     = {CPU_UDS, CPU_LDS};
        if (!RESET96) begin
            case (state)
                S_CLEAR: begin
                    vram_we = 1'b1;
                    wa_v    = cnt;
                    wa_8    = cnt[7:0];
                    wd      = 16'h0000;
                    wbe     = 2'b11;
                    if ((cnt >> 8) == '0) begin
                        sel_we = 1'b1;
                        scr_we = 1'b1;
                    end
                end
                S_IDLE: begin
                    if (!CPU_RNW) begin
                        if (CPU_CS_VRAM)     vram_we = 1'b1;
                        else if (CPU_CS_SEL) sel_we  = 1'b1;
                        else if (CPU_CS_SCR) scr_we  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cpu_rd_mux = scr[CPU_ADDR[7:0]];
        if (CPU_CS_VRAM)     cpu_rd_mux = vram[CPU_ADDR[VRAM_AW-1:0]];
        else if (CPU_CS_SEL) cpu_rd_mux = sel[CPU_ADDR[7:0]];
    end

    always_ff @(posedge CLK96) begin
        if (vram_we && wbe[1]) vram[wa_v][15:8] <= wd[15:8];
        if (vram_we && wbe[0]) vram[wa_v][7:0]  <= wd[7:0];
        if (sel_we  && wbe[1]) sel[wa_8][15:8]  <= wd[15:8];
        if (sel_we  && wbe[0]) sel[wa_8][7:0]   <= wd[7:0];
        if (scr_we  && wbe[1]) scr[wa_8][15:8]  <= wd[15:8];
        if (scr_we  && wbe[0]) scr[wa_8][7:0]   <= wd[7:0];
    end

    // Renderer ports read the pre-write contents on a same-edge collision.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            TEXTVRAM_DATA   <= 16'h0000;
            TEXTSELECT_DATA <= 16'h0000;
            TEXTSCROLL_DATA <= 16'h0000;
        end else begin
            TEXTVRAM_DATA   <= vram[TEXTVRAM_ADDR[VRAM_AW-1:0]];
            TEXTSELECT_DATA <= sel[TEXTSELECT_ADDR];
            TEXTSCROLL_DATA <= scr[TEXTSCROLL_ADDR];
        end
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            state      <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            cnt        <= '0;
            CLEAR_BUSY <= CLEAR_ON_RESET;
            CPU_DOUT   <= 16'h0000;
            CPU_DTACK  <= 1'b0;
            cpu_rd_q   <= 16'h0000;
        end else begin
            case (state)
                S_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state      <= S_IDLE;
                        CLEAR_BUSY <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (any_cs) begin
                        if (CPU_RNW) begin
                            cpu_rd_q <= cpu_rd_mux;
                            state    <= S_RD;
                        end else begin
                            CPU_DTACK <= 1'b1;
                            state     <= S_ACK;
                        end
                    end
                end
                S_RD: begin
                    if (!any_cs) begin
                        state <= S_IDLE;
                    end else begin
                        CPU_DOUT  <= cpu_rd_q;
                        CPU_DTACK <= 1'b1;
                        state     <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!any_cs) begin
                        CPU_DTACK <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/raizing_textram_ctrl.md
Name: raizing_textram_ctrl

Overview:
- Owns the three extra-text memories (text VRAM 4096x16, line-select RAM 256x16, line-scroll RAM 256x16) and serves them on both sides.
- CPU side: decoded 68000-style bus, read/write with byte lanes, DTACK handshake.
- Renderer side: three read-only ports with fixed synchronous latency, feeding the extra-text line renderer.
- Zero-fills all memories after reset.

Parameters:
- CLEAR_ON_RESET, 1, 1 = sweep all RAMs to 0 after reset; 0 = go straight to IDLE.
- VRAM_AW, 12, text VRAM word-address width.

Ports:
- CLK96  in  1  system clock.
- RESET96  in  1  reset.
- CPU_CS_VRAM  in  1  CPU access to text VRAM, level, CLK96-synchronous.
- CPU_CS_SEL  in  1  CPU access to line-select RAM.
- CPU_CS_SCR  in  1  CPU access to line-scroll RAM.
- CPU_RNW  in  1  1 = read, 0 = write.
- CPU_ADDR  in  12  word address; SEL/SCR use [7:0].
- CPU_DIN  in  16  write data.
- CPU_UDS  in  1  upper byte lane enable.
- CPU_LDS  in  1  lower byte lane enable.
- CPU_DOUT  out  16  read data.
- CPU_DTACK  out  1  access acknowledge.
- CLEAR_BUSY  out  1  high during post-reset sweep.
- TEXTVRAM_ADDR  in  12  renderer VRAM address.
- TEXTVRAM_DATA  out  16  renderer VRAM data.
- TEXTSELECT_ADDR  in  8  renderer select address.
- TEXTSELECT_DATA  out  16  renderer select data.
- TEXTSCROLL_ADDR  in  8  renderer scroll address.
- TEXTSCROLL_DATA  out  16  renderer scroll data.

Behaviour:
- Reset RESET96, asynchronous, active-high; clock CLK96.
- Reset values: CPU_DOUT=0, CPU_DTACK=0, all renderer data outputs 0, CLEAR_BUSY=CLEAR_ON_RESET, clear counter 0, FSM=CLEAR (or IDLE if CLEAR_ON_RESET=0).
- Memory contents are not reset asynchronously; the sweep provides zeroing.
- Renderer ports:
  - Synchronous read: each CLK96 edge registers the data for the address present at that edge.
  - Address changed at edge t gives valid data after edge t+1, so a renderer sampling at t+2 sees correct data.
  - Data stays stable while the address is held.
  - Always active, including during CLEAR.
- Collision: a CPU write and a renderer read to the same address on the same edge return old data to the renderer (read-first). The new data is visible from the next edge.
- FSM states:
  - CLEAR: each cycle, write 0 to VRAM[cnt]; if cnt<256, also write 0 to SEL[cnt] and SCR[cnt]. cnt increments. At cnt=4095, go to IDLE next edge and drop CLEAR_BUSY. Duration is exactly 4096 cycles. CPU requests are ignored and DTACK is held 0.
  - IDLE: when any CS is high, latch target by priority VRAM > SEL > SCR (only one RAM is accessed), plus ADDR, RNW, DIN, UDS, LDS.
    - Write: write the enabled byte lanes that edge (UDS→[15:8], LDS→[7:0]; both low → no change) and go to ACK.
    - Read: go to RD.
  - RD: RAM output registered. Next edge: CPU_DOUT ← data, CPU_DTACK ← 1, go to ACK. Read latency CS→DTACK = 2 edges.
  - ACK: hold CPU_DTACK=1. For writes, DTACK rises on the edge after the write edge. When all CS are low, DTACK ← 0 and go to IDLE.
  - No second access starts until CS has been observed low.
- CPU_DOUT holds its last read value until the next read completes.
- CS dropping during RD aborts: go to IDLE, DTACK stays 0, CPU_DOUT unchanged.
- CPU_ADDR[11:8] is ignored for SEL/SCR.
- Reset mid-operation (any state): return to reset values and restart CLEAR from cnt=0. A write on the reset edge is not performed.

Test Plan:
- Release reset → CLEAR_BUSY high exactly 4096 cycles. Afterwards, renderer reads of VRAM 0xFFF, SEL 0xFF and SCR 0x00 return 0x0000. CPU CS asserted during the sweep gets no DTACK until the sweep ends plus 1 (write) or 2 (read) cycles.
- CPU write VRAM 0x123 ← 0xABCD (UDS=LDS=1) → DTACK 1 cycle after CS; renderer sets TEXTVRAM_ADDR=0x123 at t and samples 0xABCD at t+2; DTACK drops the cycle after CS falls.
- Byte lanes: over 0xABCD at VRAM 0x123, write 0x5511 with UDS only → 0x55CD; then LDS only with 0x0022 → 0x5522; CPU read returns 0x5522 with DTACK 2 cycles after CS.
- SEL write addr 0x0F3 ← 0x0007 with CS_SEL and CS_SCR both high → SEL[0xF3]=7, SCR[0xF3] unchanged (0); TEXTSELECT_ADDR=0xF3 reads 0x0007.
- Collision: renderer holds VRAM addr 0x010 (old 0x1111); CPU writes 0x2222 there → data 0x1111 on the write edge, 0x2222 from the next edge.
- Assert RESET96 in ACK of a write → DTACK=0, CLEAR_BUSY=1 immediately; after release, full 4096-cycle sweep; the written location reads 0.
